// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM state enum, size codes, byte-enable constants and lane helpers.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   function automatic logic [31:0] sext16(input logic [15:0] h);
      return {{16{h[15]}}, h};
   endfunction

   // Illegal size codes count as misaligned so they never reach memory.
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] a
   );
      logic m;
      case (size)
         SZ_HALF: m = a[0];
         SZ_WORD: m = |a;
         default: m = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane aligner: store byte enables / lane replication,
// load extraction with halfword sign extension, and misalignment flag.
// Ports:
//   size  in  2   access size code (SZ_HALF / SZ_WORD)
//   a     in  2   byte offset within the word
//   wdata in  32  raw store data
//   rdata in  32  raw memory read word
//   mis   out 1   access is misaligned or has an illegal size
//   be    out 4   byte enables
//   wlane out 32  lane-replicated store data
//   rext  out 32  extracted (and sign-extended) load data
module dmem_lane_align
   import dmem_arb_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  a,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        mis,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] rext
);

   always_comb begin
      mis   = misaligned(size, a);
      be    = BE_ALL;
      wlane = wdata;
      rext  = rdata;
      if (size != SZ_WORD) begin
         be    = a[1] ? BE_HI : BE_LO;
         wlane = {2{wdata[15:0]}};
         rext  = sext16(a[1] ? rdata[31:16]
                             : rdata[15:0]);
      end
   end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Single-port data memory owner: arbitrates pipeline MEM-stage and debug
// word accesses, sequences IDLE->ISSUE->WAIT->RESP, aligns halfword lanes.
// Optional macro ARB_FAIR_EN: after MAX_PIPE_GRANTS consecutive pipeline
// grants taken while d_req waits, the next arbitration goes to debug.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   p_req/we/size/addr/wdata pipeline request (held until p_done)
//   p_rdata/p_done/p_err    pipeline response (one-cycle done pulse)
//   stall_o                 p_req & ~p_done
//   d_req/we/addr/wdata     debug word request (held until d_done)
//   d_rdata/d_done          debug response
//   m_en/we/be/addr/wdata   memory strobe and write side
//   m_rdata                 memory read data, LATENCY cycles after m_en
module dmem_access_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W          = 12,
   parameter int LATENCY         = 1,
   parameter int MAX_PIPE_GRANTS = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [1:0]        p_size,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [31:0]       p_wdata,
   output logic [31:0]       p_rdata,
   output logic              p_done,
   output logic              p_err,
   output logic              stall_o,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   output logic              m_en,
   output logic              m_we,
   output logic [3:0]        m_be,
   output logic [ADDR_W-3:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);

   if (LATENCY < 1 || LATENCY > 15 ||
       MAX_PIPE_GRANTS < 1) begin : g_bad_cfg
      $error("dmem_access_arbiter: bad parameters");
   end

   state_t state;

   logic       own_dbg;
   logic       l_we;
   logic [1:0] l_size;
   logic [1:0] l_a;
   logic [3:0] wcnt;

   logic              dbg_pref;
   logic              p_win;
   logic              sel_we;
   logic [1:0]        sel_size;
   logic [1:0]        sel_a;
   logic [ADDR_W-3:0] sel_waddr;
   logic [31:0]       sel_wdata;

   logic [1:0]  al_size;
   logic [1:0]  al_a;
   logic        al_mis;
   logic [3:0]  al_be;
   logic [31:0] al_wlane;
   logic [31:0] al_rext;

`ifdef ARB_FAIR_EN
   localparam int CW = $clog2(MAX_PIPE_GRANTS + 1);
   logic [CW-1:0] fcnt;

   assign dbg_pref = d_req &
      (fcnt >= CW'(MAX_PIPE_GRANTS));
`else
   assign dbg_pref = 1'b0;
`endif

   assign p_win   = p_req & ~dbg_pref;
   assign stall_o = p_req & ~p_done;

   // Debug is always a word access; its low
   // address bits ride along but are ignored.
   always_comb begin
      sel_we    = d_we;
      sel_size  = SZ_WORD;
      sel_a     = d_addr[1:0];
      sel_waddr = d_addr[ADDR_W-1:2];
      sel_wdata = d_wdata;
      if (p_win) begin
         sel_we    = p_we;
         sel_size  = p_size;
         sel_a     = p_addr[1:0];
         sel_waddr = p_addr[ADDR_W-1:2];
         sel_wdata = p_wdata;
      end
   end

   // In IDLE the aligner sees the incoming
   // winner (store lanes registered into
   // m_*); later it sees the latched access
   // for load extraction.
   assign al_size = (state == ST_IDLE) ?
                    sel_size : l_size;
   assign al_a    = (state == ST_IDLE) ?
                    sel_a : l_a;

   dmem_lane_align u_align (
      .size  (al_size),
      .a     (al_a),
      .wdata (sel_wdata),
      .rdata (m_rdata),
      .mis   (al_mis),
      .be    (al_be),
      .wlane (al_wlane),
      .rext  (al_rext)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         own_dbg <= 1'b0;
         l_we    <= 1'b0;
         l_size  <= 2'b00;
         l_a     <= 2'b00;
         wcnt    <= 4'd0;
         p_rdata <= 32'd0;
         p_done  <= 1'b0;
         p_err   <= 1'b0;
         d_rdata <= 32'd0;
         d_done  <= 1'b0;
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_be    <= 4'd0;
         m_addr  <= '0;
         m_wdata <= 32'd0;
`ifdef ARB_FAIR_EN
         fcnt    <= '0;
`endif
      end else begin
         p_done <= 1'b0;
         p_err  <= 1'b0;
         d_done <= 1'b0;
         m_en   <= 1'b0;
         m_we   <= 1'b0;
         m_be   <= 4'd0;
`ifdef ARB_FAIR_EN
         if (!d_req)
            fcnt <= '0;
`endif
         unique case (state)
            ST_IDLE: begin
               if (p_req | d_req) begin
                  own_dbg <= ~p_win;
                  l_we    <= sel_we;
                  l_size  <= sel_size;
                  l_a     <= sel_a;
`ifdef ARB_FAIR_EN
                  if (!p_win)
                     fcnt <= '0;
                  else if (d_req)
                     fcnt <= fcnt + CW'(1);
`endif
                  if (p_win && al_mis) begin
                     // Bad pipeline access: answer
                     // directly, memory untouched.
                     state   <= ST_RESP;
                     p_done  <= 1'b1;
                     p_err   <= 1'b1;
                     p_rdata <= 32'd0;
                  end else begin
                     state   <= ST_ISSUE;
                     m_en    <= 1'b1;
                     m_we    <= sel_we;
                     m_be    <= al_be;
                     m_addr  <= sel_waddr;
                     m_wdata <= al_wlane;
                  end
               end
            end
            ST_ISSUE: begin
               if (l_we) begin
                  state <= ST_RESP;
                  if (own_dbg) begin
                     d_done  <= 1'b1;
                     d_rdata <= 32'd0;
                  end else begin
                     p_done  <= 1'b1;
                     p_rdata <= 32'd0;
                  end
               end else begin
                  state <= ST_WAIT;
                  wcnt  <= 4'(LATENCY - 1);
               end
            end
            ST_WAIT: begin
               if (wcnt == 4'd0) begin
                  state <= ST_RESP;
                  if (own_dbg) begin
                     d_done  <= 1'b1;
                     d_rdata <= al_rext;
                  end else begin
                     p_done  <= 1'b1;
                     p_rdata <= al_rext;
                  end
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
